// File: rtl/serial_bit_tx.sv
// Serial frame transmitter: start bit, DATA_W payload bits LSB-first, optional parity, stop bit.
// Build with SERIAL_TX_PARITY_EN defined to insert an even-parity bit between payload and stop.
module serial_bit_tx #(
  parameter int   DATA_W     = 8,
  parameter int   BIT_DIV    = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                out_q, out_d;
  logic                done_q, done_d;
  logic                slot_end;
`ifdef SERIAL_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  // Frame sequencing: next state, divider, bit index and shift register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d    = par_q;
`endif
    slot_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = IN_DATA;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = even_parity(IN_DATA);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (slot_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (slot_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (slot_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Line level and DONE are decoded from the next state so they register on the same edge.
  always_comb begin
    out_d  = IDLE_LEVEL;
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
    case (state_d)
      S_IDLE:   out_d = IDLE_LEVEL;
      S_START:  out_d = ~IDLE_LEVEL;
      S_DATA:   out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: out_d = par_d;
`endif
      S_STOP:   out_d = IDLE_LEVEL;
      default:  out_d = IDLE_LEVEL;
    endcase
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign IN_READY = (state_q == S_IDLE);
  assign BUSY     = (state_q != S_IDLE);
  assign OUT      = out_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: a default instance (8 bits, div 4) and a minimal one (1 bit, div 1).
module tb_serial_bit_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LEN_A = (8 + 2 + PAR) * 4;
  localparam int LEN_B = (1 + 2 + PAR) * 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_ready, a_out, a_busy, a_done;
  logic       b_valid = 1'b0;
  logic [0:0] b_data = 1'b0;
  logic       b_ready, b_out, b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_out_q[$];
  bit exp_done_q[$];

  serial_bit_tx #(.DATA_W(8), .BIT_DIV(4), .IDLE_LEVEL(1'b1)) dut_a (
    .CLK(clk), .RST(rst_n), .IN_VALID(a_valid), .IN_DATA(a_data),
    .IN_READY(a_ready), .OUT(a_out), .BUSY(a_busy), .DONE(a_done)
  );

  serial_bit_tx #(.DATA_W(1), .BIT_DIV(1), .IDLE_LEVEL(1'b1)) dut_b (
    .CLK(clk), .RST(rst_n), .IN_VALID(b_valid), .IN_DATA(b_data),
    .IN_READY(b_ready), .OUT(b_out), .BUSY(b_busy), .DONE(b_done)
  );

  always #5 clk = ~clk;

  // Reference frame: expected line level and DONE for every cycle of one frame.
  task automatic push_frame(input logic [7:0] w, input int dw, input int div);
    bit lv[$];
    bit p = 1'b0;
    lv.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      lv.push_back(w[i]);
      p ^= w[i];
    end
    if (PAR != 0) lv.push_back(p);
    lv.push_back(1'b1);
    foreach (lv[k]) begin
      for (int j = 0; j < div; j++) begin
        exp_out_q.push_back(lv[k]);
        exp_done_q.push_back((k == lv.size() - 1) && (j == div - 1));
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({a_out, a_ready, a_busy, a_done} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: out/ready/busy/done=%b expected 1100", c, {a_out, a_ready, a_busy, a_done});
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({a_out, a_ready, a_busy, a_done, b_out, b_ready} !== 6'b110011) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: a out/ready/busy/done,b out/ready=%b expected 110011", c, {a_out, a_ready, a_busy, a_done, b_out, b_ready});
      end
    end
  endtask

  task automatic test_single(input logic [7:0] w);
    bit eo, ed;
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready_pre: got %b expected 1", a_ready);
    end
    a_valid = 1'b1;
    a_data  = w;
    push_frame(w, 8, 4);
    @(posedge clk);
    for (int c = 1; c <= LEN_A; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a_valid = 1'b0;
        a_data  = ~w;
      end
      eo = exp_out_q.pop_front();
      ed = exp_done_q.pop_front();
      n_checks++;
      if ({a_out, a_done, a_busy, a_ready} !== {eo, ed, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_%h cyc %0d: out/done/busy/ready=%b expected %b", w, c, {a_out, a_done, a_busy, a_ready}, {eo, ed, 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({a_out, a_done, a_busy, a_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL single_%h_after: out/done/busy/ready=%b expected 1001", w, {a_out, a_done, a_busy, a_ready});
    end
  endtask

  task automatic test_back_to_back();
    bit eo, ed;
    int total = 2 * LEN_A + 1;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'h3C;
    push_frame(8'h3C, 8, 4);
    exp_out_q.push_back(1'b1);
    exp_done_q.push_back(1'b0);
    push_frame(8'hFF, 8, 4);
    @(posedge clk);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (c == 5) a_data = 8'hFF;
      if (c == LEN_A + 2) a_valid = 1'b0;
      eo = exp_out_q.pop_front();
      ed = exp_done_q.pop_front();
      n_checks++;
      if ({a_out, a_done} !== {eo, ed}) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: out/done=%b expected %b", c, {a_out, a_done}, {eo, ed});
      end
      if (c == LEN_A || c == LEN_A + 1 || c == LEN_A + 2) begin
        n_checks++;
        if (a_ready !== (c == LEN_A + 1)) begin
          n_fail++;
          $display("FAIL b2b_ready cyc %0d: got %b expected %b", c, a_ready, (c == LEN_A + 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit eo, ed;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'h00;
    push_frame(8'h00, 8, 4);
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) a_valid = 1'b0;
      eo = exp_out_q.pop_front();
      ed = exp_done_q.pop_front();
      n_checks++;
      if ({a_out, a_done} !== {eo, ed}) begin
        n_fail++;
        $display("FAIL rstmid_pre cyc %0d: out/done=%b expected %b", c, {a_out, a_done}, {eo, ed});
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_out, a_done, a_busy, a_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL rstmid_async: out/done/busy/ready=%b expected 1001", {a_out, a_done, a_busy, a_ready});
    end
    exp_out_q.delete();
    exp_done_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({a_out, a_done} !== 2'b10) begin
        n_fail++;
        $display("FAIL rstmid_hold cyc %0d: out/done=%b expected 10", c, {a_out, a_done});
      end
    end
    rst_n = 1'b1;
    test_single(8'h81);
  endtask

  task automatic test_min_div();
    bit eo, ed;
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = 1'b1;
    push_frame(8'h01, 1, 1);
    @(posedge clk);
    for (int c = 1; c <= LEN_B; c++) begin
      @(negedge clk);
      if (c == 1) begin
        b_valid = 1'b0;
        b_data  = 1'b0;
      end
      eo = exp_out_q.pop_front();
      ed = exp_done_q.pop_front();
      n_checks++;
      if ({b_out, b_done, b_busy} !== {eo, ed, 1'b1}) begin
        n_fail++;
        $display("FAIL mindiv cyc %0d: out/done/busy=%b expected %b", c, {b_out, b_done, b_busy}, {eo, ed, 1'b1});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({b_out, b_done, b_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL mindiv_after: out/done/ready=%b expected 101", {b_out, b_done, b_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_back_to_back();
    test_reset_mid();
    test_min_div();
    test_single(8'h07);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
